// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with split-transaction parking and owner timeout
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   txn_done,
    input  logic                   split_req,
    input  logic [SW-1:0]          split_slave,
    input  logic [NUM_SLAVES-1:0]  split_ready,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [MW-1:0]          owner,
    output logic                   bus_busy,
    output logic [NUM_MASTERS-1:0] split_pending,
    output logic                   timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
    // Release fires on the edge that closes the TIMEOUT_CYCLES-th owned cycle.
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SW:0] NS_W = (SW + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWNED,
        S_HANDOVER
    } state_t;

    state_t                 state;
    logic [SW-1:0]          pslave [NUM_MASTERS];
    logic [MW-1:0]          last;
    logic [CW-1:0]          cnt;
    logic [NUM_MASTERS-1:0] eligible;
    logic                   found;
    logic [MW-1:0]          win;
    logic                   ev_abort;
    logic                   ev_to;
    logic                   any_exit;
    logic                   timeout_only;
    logic                   rec_split;

    // A parked master may only compete again once its splitting slave is ready.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = req[i] && (!split_pending[i] || split_ready[pslave[i]]);
        end
    end

    // Winner selection: resuming split masters by lowest index, else round-robin after last.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && eligible[i] && split_pending[i]) begin
                found = 1'b1;
                win   = MW'(i);
            end
        end
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            idx = int'(last) + off;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && eligible[idx[MW-1:0]]) begin
                found = 1'b1;
                win   = idx[MW-1:0];
            end
        end
    end

    // Exit events while owned; txn_done outranks split, split outranks abort, abort outranks timeout.
    always_comb begin
        ev_abort     = !req[owner];
        ev_to        = TO_EN && (cnt >= TLIM);
        any_exit     = txn_done || split_req || ev_abort || ev_to;
        timeout_only = ev_to && !txn_done && !split_req && !ev_abort;
        rec_split    = split_req && !txn_done && ({1'b0, split_slave} < NS_W);
    end

    // Arbiter state machine with registered grant/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            grant         <= '0;
            owner         <= '0;
            bus_busy      <= 1'b0;
            split_pending <= '0;
            timeout       <= 1'b0;
            last          <= MW'(NUM_MASTERS - 1);
            cnt           <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                pslave[i] <= '0;
            end
        end else begin
            // A parked master that stops requesting gives up its split slot.
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (split_pending[i] && !req[i] && !grant[i]) begin
                    split_pending[i] <= 1'b0;
                end
            end
            case (state)
                S_IDLE: begin
                    timeout <= 1'b0;
                    if (found) begin
                        state              <= S_OWNED;
                        grant              <= NUM_MASTERS'(1) << win;
                        owner              <= win;
                        last               <= win;
                        bus_busy           <= 1'b1;
                        cnt                <= '0;
                        split_pending[win] <= 1'b0;
                    end
                end
                S_OWNED: begin
                    if (any_exit) begin
                        state   <= S_HANDOVER;
                        grant   <= '0;
                        timeout <= timeout_only;
                        if (rec_split) begin
                            split_pending[owner] <= 1'b1;
                            pslave[owner]        <= split_slave;
                        end
                    end else if (cnt != TMAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HANDOVER: begin
                    state    <= S_IDLE;
                    bus_busy <= 1'b0;
                    timeout  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic       txn_done;
    logic       split_req;
    logic [1:0] split_slave;
    logic [2:0] split_ready;
    logic [1:0] grant;
    logic       owner;
    logic       bus_busy;
    logic [1:0] split_pending;
    logic       timeout;
    logic [1:0] nt_grant;
    logic       nt_owner;
    logic       nt_busy;
    logic [1:0] nt_pend;
    logic       nt_timeout;

    int checks = 0;
    int errors = 0;

    // reference model: transaction view of the bus
    bit         m_held;
    int         m_gap;
    int         m_age;
    int         m_last;
    bit [1:0]   m_park;
    int         m_pslave [NM];
    logic [1:0] e_grant;
    logic       e_owner;
    logic       e_busy;
    logic       e_to;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .txn_done(txn_done),
        .split_req(split_req), .split_slave(split_slave), .split_ready(split_ready),
        .grant(grant), .owner(owner), .bus_busy(bus_busy),
        .split_pending(split_pending), .timeout(timeout)
    );

    bus_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n), .req(req), .txn_done(txn_done),
        .split_req(split_req), .split_slave(split_slave), .split_ready(split_ready),
        .grant(nt_grant), .owner(nt_owner), .bus_busy(nt_busy),
        .split_pending(nt_pend), .timeout(nt_timeout)
    );

    task automatic model_reset();
        m_held  = 1'b0;
        m_gap   = 0;
        m_age   = 0;
        m_last  = NM - 1;
        m_park  = '0;
        for (int i = 0; i < NM; i++) m_pslave[i] = 0;
        e_grant = '0;
        e_owner = 1'b0;
        e_busy  = 1'b0;
        e_to    = 1'b0;
    endtask

    task automatic model_step();
        bit [1:0] np;
        bit       fnd;
        int       w;
        int       j;
        bit       ab;
        bit       tm;
        np   = m_park;
        for (int i = 0; i < NM; i++) if (m_park[i] && !req[i]) np[i] = 1'b0;
        e_to = 1'b0;
        if (m_held) begin
            m_age = m_age + 1;
            ab = !req[e_owner];
            tm = (TO > 0) && (m_age >= TO);
            if (txn_done || split_req || ab || tm) begin
                m_held  = 1'b0;
                m_gap   = 1;
                e_grant = '0;
                e_to    = tm && !txn_done && !split_req && !ab;
                if (split_req && !txn_done && int'(split_slave) < NS) begin
                    np[e_owner]       = 1'b1;
                    m_pslave[e_owner] = int'(split_slave);
                end
            end
        end else if (m_gap > 0) begin
            m_gap  = 0;
            e_busy = 1'b0;
        end else begin
            fnd = 1'b0;
            w   = 0;
            for (int i = 0; i < NM; i++) begin
                if (!fnd && m_park[i] && req[i] && split_ready[m_pslave[i]]) begin
                    fnd = 1'b1;
                    w   = i;
                end
            end
            for (int k = 1; k <= NM; k++) begin
                j = (m_last + k) % NM;
                if (!fnd && req[j] && (!m_park[j] || split_ready[m_pslave[j]])) begin
                    fnd = 1'b1;
                    w   = j;
                end
            end
            if (fnd) begin
                m_held  = 1'b1;
                m_age   = 0;
                m_last  = w;
                e_grant = 2'(1 << w);
                e_owner = 1'(w);
                e_busy  = 1'b1;
                np[w]   = 1'b0;
            end
        end
        m_park = np;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req         = '0;
        txn_done    = 1'b0;
        split_req   = 1'b0;
        split_slave = '0;
        split_ready = '0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got=%b exp=0", owner); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_busy); end
        checks++; if (split_pending !== 2'b00) begin errors++; $display("FAIL reset_pend got=%b exp=00", split_pending); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    endtask

    task automatic test_single();
        apply_reset();
        req = 2'b01;
        cycle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", grant); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL single_owner got=%b exp=0", owner); end
        checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus_busy); end
        txn_done = 1'b1;
        cycle();
        txn_done = 1'b0;
        checks++; if (grant !== 2'b00 || bus_busy !== 1'b1) begin errors++; $display("FAIL single_handover grant=%b busy=%b exp=00/1", grant, bus_busy); end
        cycle();
        checks++; if (grant !== 2'b00 || bus_busy !== 1'b0) begin errors++; $display("FAIL single_idle grant=%b busy=%b exp=00/0", grant, bus_busy); end
        cycle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_regrant got=%b exp=01", grant); end
        req = 2'b00;
        cycle(); cycle(); cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [4];
        int         wait_n;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        apply_reset();
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_n = 0;
            while (grant === 2'b00 && wait_n < 10) begin
                cycle();
                wait_n++;
            end
            checks++; if (grant !== exp_seq[g]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", g, grant, exp_seq[g]); end
            for (int k = 0; k < 4; k++) cycle();
            txn_done = 1'b1;
            cycle();
            txn_done = 1'b0;
        end
        req = 2'b00;
        cycle(); cycle();
    endtask

    task automatic test_split();
        apply_reset();
        req = 2'b01;
        cycle();
        req         = 2'b11;
        split_req   = 1'b1;
        split_slave = 2'd2;
        cycle();
        split_req = 1'b0;
        checks++; if (split_pending !== 2'b01 || grant !== 2'b00) begin errors++; $display("FAIL split_park pend=%b grant=%b exp=01/00", split_pending, grant); end
        cycle(); cycle();
        checks++; if (grant !== 2'b10 || split_pending !== 2'b01) begin errors++; $display("FAIL split_other grant=%b pend=%b exp=10/01", grant, split_pending); end
        split_ready = 3'b100;
        txn_done    = 1'b1;
        cycle();
        txn_done = 1'b0;
        cycle(); cycle();
        checks++; if (grant !== 2'b01 || split_pending !== 2'b00) begin errors++; $display("FAIL split_resume grant=%b pend=%b exp=01/00", grant, split_pending); end
        req = 2'b00;
        split_ready = '0;
        cycle(); cycle(); cycle();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req = 2'b01;
        cycle();
        txn_done    = 1'b1;
        split_req   = 1'b1;
        split_slave = 2'd1;
        cycle();
        txn_done  = 1'b0;
        split_req = 1'b0;
        checks++; if (grant !== 2'b00 || split_pending !== 2'b00) begin errors++; $display("FAIL simul_done_split grant=%b pend=%b exp=00/00", grant, split_pending); end
        cycle(); cycle();
        split_req   = 1'b1;
        split_slave = 2'd3;
        cycle();
        split_req = 1'b0;
        checks++; if (grant !== 2'b00 || split_pending !== 2'b00 || timeout !== 1'b0) begin errors++; $display("FAIL split_bad_slave grant=%b pend=%b to=%b exp=00/00/0", grant, split_pending, timeout); end
        req = 2'b00;
        cycle(); cycle();
    endtask

    task automatic test_timeout();
        int high;
        apply_reset();
        req = 2'b01;
        cycle();
        high = (grant === 2'b01) ? 1 : 0;
        for (int k = 0; k < 20 && grant === 2'b01; k++) begin
            cycle();
            if (grant === 2'b01) high++;
        end
        checks++; if (high != TO) begin errors++; $display("FAIL timeout_len got=%0d exp=%0d", high, TO); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got=%b exp=1", timeout); end
        req = 2'b00;
        cycle();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", timeout); end
        cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 2'b10;
        cycle();
        req         = 2'b11;
        split_req   = 1'b1;
        split_slave = 2'd0;
        cycle();
        split_req = 1'b0;
        cycle(); cycle();
        checks++; if (grant !== 2'b01 || split_pending !== 2'b10) begin errors++; $display("FAIL rmid_setup grant=%b pend=%b exp=01/10", grant, split_pending); end
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || split_pending !== 2'b00 || bus_busy !== 1'b0) begin errors++; $display("FAIL rmid_async grant=%b pend=%b busy=%b exp=00/00/0", grant, split_pending, bus_busy); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 2'b11;
        cycle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_first got=%b exp=01", grant); end
        req = 2'b00;
        cycle(); cycle(); cycle();
    endtask

    task automatic test_no_timeout();
        apply_reset();
        req = 2'b01;
        cycle();
        for (int k = 0; k < 40; k++) begin
            checks++; if (nt_grant !== 2'b01 || nt_timeout !== 1'b0) begin errors++; $display("FAIL notimeout_hold cyc=%0d grant=%b to=%b exp=01/0", k, nt_grant, nt_timeout); end
            cycle();
        end
        req = 2'b00;
        cycle(); cycle(); cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NM; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            for (int i = 0; i < NS; i++) if ($urandom_range(0, 5) == 0) split_ready[i] = ~split_ready[i];
            txn_done    = ($urandom_range(0, 5) == 0);
            split_req   = ($urandom_range(0, 6) == 0);
            split_slave = 2'($urandom_range(0, 3));
            cycle();
            checks++; if (grant !== e_grant) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, grant, e_grant); end
            checks++; if (owner !== e_owner) begin errors++; $display("FAIL rnd_owner cyc=%0d got=%b exp=%b", c, owner, e_owner); end
            checks++; if (bus_busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, bus_busy, e_busy); end
            checks++; if (split_pending !== m_park) begin errors++; $display("FAIL rnd_pend cyc=%0d got=%b exp=%b", c, split_pending, m_park); end
            checks++; if (timeout !== e_to) begin errors++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", c, timeout, e_to); end
        end
        txn_done  = 1'b0;
        split_req = 1'b0;
        req       = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        txn_done    = 1'b0;
        split_req   = 1'b0;
        split_slave = '0;
        split_ready = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_split();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_no_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
